// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD keypad encoder.
//   state_t        : encoder FSM states
//   bcd_digit_t    : one BCD digit
//   BCD_MAX        : largest legal BCD digit
//   onehot_to_bcd  : encode a one-hot 10-bit key pattern as a BCD digit
//   is_onehot      : true when exactly one of ten key lines is set
//   is_multi       : true when two or more key lines are set
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    HOLD,
    RELEASE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t onehot_to_bcd(input logic [9:0] onehot);
    bcd_digit_t r;
    r = '0;
    for (int i = 0; i <= int'(BCD_MAX); i++) begin
      if (onehot[i]) r = bcd_digit_t'(i);
    end
    return r;
  endfunction

  // Clearing the lowest set bit leaves zero only for a single-bit pattern.
  function automatic logic is_multi(input logic [9:0] v);
    return (v & (v - 10'd1)) != 10'd0;
  endfunction

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && !is_multi(v);
  endfunction

endpackage

// File: rtl/key_sync.sv
// Parameterized two-flop synchronizer for asynchronous input lines.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears both stages
//   i_d   : asynchronous input lines
//   o_q   : synchronized lines, two clocks behind i_d
module key_sync #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/bcd_keypad_encoder.sv
// Keypad-to-BCD encoder: synchronizes ten raw key lines, debounces a single
// one-hot press, offers it once over valid/ready and shifts it into a
// multi-digit entry register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   keys         : raw key lines, bit i = digit i pressed
//   clear        : synchronous clear of entry and entry_count
//   digit_bcd    : offered digit (valid while digit_valid)
//   digit_valid  : debounced press offered
//   digit_ready  : consumer accepts the offered digit
//   multi_key    : two or more synchronized keys held
//   entry        : accepted digits, newest in [3:0]
//   entry_count  : number of valid digits in entry, saturating at NDIGITS
module bcd_keypad_encoder
  import bcd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned NDIGITS         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [9:0]             keys,
  input  logic                   clear,
  output logic [3:0]             digit_bcd,
  output logic                   digit_valid,
  input  logic                   digit_ready,
  output logic                   multi_key,
  output logic [4*NDIGITS-1:0]   entry,
  output logic [3:0]             entry_count
);

  localparam int unsigned EntryW   = 4 * NDIGITS;
  localparam logic [15:0] DebCnt   = 16'(DEBOUNCE_CYCLES);
  localparam logic [3:0]  CountMax = 4'(NDIGITS);
  // With a one-cycle debounce the first one-hot sample already satisfies it.
  localparam bit          ShortDeb = (DEBOUNCE_CYCLES <= 1);

  logic [9:0]        w_key_s;
  logic              w_onehot;
  logic              w_xfer;
  logic [15:0]       w_cnt_inc;
  logic [EntryW-1:0] w_entry_shift;

  state_t            r_state;
  logic [15:0]       r_cnt;
  logic [9:0]        r_pat;
  bcd_digit_t        r_digit_bcd;
  logic              r_digit_valid;
  logic [EntryW-1:0] r_entry;
  logic [3:0]        r_count;

  key_sync #(
    .WIDTH (10)
  ) u_key_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (keys),
    .o_q   (w_key_s)
  );

  assign w_onehot  = is_onehot(w_key_s);
  assign multi_key = is_multi(w_key_s);
  assign w_xfer    = r_digit_valid & digit_ready;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

  // Shift left by one digit; the oldest digit falls off the top.
  assign w_entry_shift = (r_entry << 4) | EntryW'(r_digit_bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_pat         <= '0;
      r_digit_bcd   <= '0;
      r_digit_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_onehot) begin
            r_pat <= w_key_s;
            r_cnt <= 16'd1;
            if (ShortDeb) begin
              r_digit_bcd   <= onehot_to_bcd(w_key_s);
              r_digit_valid <= 1'b1;
              r_state       <= HOLD;
            end else begin
              r_state <= BOUNCE;
            end
          end
        end
        BOUNCE: begin
          if (w_key_s == r_pat) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= DebCnt) begin
              r_digit_bcd   <= onehot_to_bcd(r_pat);
              r_digit_valid <= 1'b1;
              r_state       <= HOLD;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        end
        HOLD: begin
          // The offer stands even if the key is released before acceptance.
          if (digit_ready) begin
            r_digit_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_key_s == 10'd0) begin
            if (w_cnt_inc >= DebCnt) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        default: begin
          r_cnt         <= '0;
          r_digit_valid <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident transfer; the handshake itself
  // still completes in the FSM above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_entry <= '0;
      r_count <= '0;
    end else if (w_xfer) begin
      r_entry <= w_entry_shift;
      r_count <= (r_count >= CountMax) ? CountMax : r_count + 4'd1;
    end
  end

  assign digit_bcd   = r_digit_bcd;
  assign digit_valid = r_digit_valid;
  assign entry       = r_entry;
  assign entry_count = r_count;

endmodule
